// File: rtl/csr_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : csr_wport_arbiter
// Purpose  : Shares the single CSR-file write port between three requesters:
//            the trap/interrupt sequencer (multi-beat atomic bursts), EXU CSR
//            instruction writeback, and the counter updater. Traps have fixed
//            priority and their bursts are locked. EXU and counter share
//            round-robin. A counter that is starved for MAX_WAIT cycles is
//            boosted above an unlocked trap. The write port is registered,
//            giving one cycle of latency.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_trap_*          trap-sequencer request (valid/last/addr/data), o_trap_ready
//   i_exu_*           EXU CSR writeback request (valid/addr/data), o_exu_ready
//   i_cnt_*           counter-update request (valid/addr/data), o_cnt_ready
//   o_csr_wen/waddr/wdata  registered write port to the CSR file
//   o_grant           registered one-hot {cnt, exu, trap} of the source written
//   o_busy            stall indication: burst lock or any request left waiting
// ============================================================================
module csr_wport_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 64,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              i_trap_valid,
   input  logic              i_trap_last,
   input  logic [ADDR_W-1:0] i_trap_addr,
   input  logic [DATA_W-1:0] i_trap_data,
   output logic              o_trap_ready,

   input  logic              i_exu_valid,
   input  logic [ADDR_W-1:0] i_exu_addr,
   input  logic [DATA_W-1:0] i_exu_data,
   output logic              o_exu_ready,

   input  logic              i_cnt_valid,
   input  logic [ADDR_W-1:0] i_cnt_addr,
   input  logic [DATA_W-1:0] i_cnt_data,
   output logic              o_cnt_ready,

   output logic              o_csr_wen,
   output logic [ADDR_W-1:0] o_csr_waddr,
   output logic [DATA_W-1:0] o_csr_wdata,
   output logic [2:0]        o_grant,
   output logic              o_busy
);

   // Saturation value of the starvation counter, sized to the counter.
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   // Bit positions within the one-hot grant vector.
   localparam int GNT_TRAP = 0;
   localparam int GNT_EXU  = 1;
   localparam int GNT_CNT  = 2;

   // -------------------------------------------------------------------------
   // Arbitration state
   // -------------------------------------------------------------------------
   logic       lock;      // trap burst in progress; only trap may be served
   logic       rr_ptr;    // 0: exu preferred, 1: cnt preferred
   logic [7:0] wait_cnt;  // consecutive cycles the counter has been denied

   logic       boost;
   logic [2:0] gnt;       // combinational one-hot grant for this cycle
   logic       trap_xfer;
   logic       exu_xfer;
   logic       cnt_xfer;
   logic       any_xfer;

   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   assign boost = (wait_cnt == MAX_WAIT_C);

   // -------------------------------------------------------------------------
   // Grant selection. Ready is derived only from valids and registered state,
   // so no requester's ready can feed back into itself.
   // -------------------------------------------------------------------------
   always_comb begin
      gnt = 3'b000;
      if (!rst_n) begin
         gnt = 3'b000;
      end else if (lock) begin
         // A locked burst is atomic: even a boosted counter waits, and a gap
         // in the burst produces no grant at all.
         gnt[GNT_TRAP] = i_trap_valid;
      end else if (boost && i_cnt_valid) begin
         gnt[GNT_CNT] = 1'b1;
      end else if (i_trap_valid) begin
         gnt[GNT_TRAP] = 1'b1;
      end else if (i_exu_valid && i_cnt_valid) begin
         if (rr_ptr) begin
            gnt[GNT_CNT] = 1'b1;
         end else begin
            gnt[GNT_EXU] = 1'b1;
         end
      end else if (i_exu_valid) begin
         gnt[GNT_EXU] = 1'b1;
      end else if (i_cnt_valid) begin
         gnt[GNT_CNT] = 1'b1;
      end
   end

   assign o_trap_ready = gnt[GNT_TRAP];
   assign o_exu_ready  = gnt[GNT_EXU];
   assign o_cnt_ready  = gnt[GNT_CNT];

   // Grants are only ever raised for a valid source, so grant == transfer.
   assign trap_xfer = gnt[GNT_TRAP];
   assign exu_xfer  = gnt[GNT_EXU];
   assign cnt_xfer  = gnt[GNT_CNT];
   assign any_xfer  = trap_xfer | exu_xfer | cnt_xfer;

   // -------------------------------------------------------------------------
   // Stall output. Held low in reset because all readies are forced low
   // there and the stall must not be reported against a dead arbiter.
   // -------------------------------------------------------------------------
   always_comb begin
      o_busy = 1'b0;
      if (rst_n) begin
         o_busy = lock
                | (i_trap_valid & ~o_trap_ready)
                | (i_exu_valid  & ~o_exu_ready)
                | (i_cnt_valid  & ~o_cnt_ready);
      end
   end

   // -------------------------------------------------------------------------
   // Write-data mux. Zero when nothing transfers so the registered port reads
   // all-zero on idle cycles.
   // -------------------------------------------------------------------------
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      unique case (1'b1)
         trap_xfer: begin
            sel_addr = i_trap_addr;
            sel_data = i_trap_data;
         end
         exu_xfer: begin
            sel_addr = i_exu_addr;
            sel_data = i_exu_data;
         end
         cnt_xfer: begin
            sel_addr = i_cnt_addr;
            sel_data = i_cnt_data;
         end
         default: begin
            sel_addr = '0;
            sel_data = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State update
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // Dropping the lock here means an interrupted burst is abandoned;
         // the trap sequencer restarts it from its first beat.
         lock     <= 1'b0;
         rr_ptr   <= 1'b0;
         wait_cnt <= 8'd0;
      end else begin
         if (trap_xfer) begin
            lock <= ~i_trap_last;
         end

         if (exu_xfer) begin
            rr_ptr <= 1'b1;
         end else if (cnt_xfer) begin
            rr_ptr <= 1'b0;
         end

         // Counts consecutive denials only; any gap in the counter request
         // or any counter transfer starts the count afresh.
         if (i_cnt_valid && !cnt_xfer) begin
            if (wait_cnt != MAX_WAIT_C) begin
               wait_cnt <= wait_cnt + 8'd1;
            end
         end else begin
            wait_cnt <= 8'd0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Registered write port
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_csr_wen   <= 1'b0;
         o_csr_waddr <= '0;
         o_csr_wdata <= '0;
         o_grant     <= 3'b000;
      end else begin
         o_csr_wen   <= any_xfer;
         o_csr_waddr <= sel_addr;
         o_csr_wdata <= sel_data;
         o_grant     <= gnt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_csr_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_wport_arbiter
// Purpose  : Self-checking bench for csr_wport_arbiter. Stimulus drives the
//            requesters on the falling edge, checks readies/busy against a
//            reference model and queues the expected write-port contents; a
//            separate monitor pops and compares after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_wport_arbiter;

   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 64;
   localparam int MAX_WAIT = 4;

   logic              clk;
   logic              rst_n;
   logic              trap_valid, trap_last, exu_valid, cnt_valid;
   logic [ADDR_W-1:0] trap_addr, exu_addr, cnt_addr;
   logic [DATA_W-1:0] trap_data, exu_data, cnt_data;
   logic              trap_ready, exu_ready, cnt_ready;
   logic              csr_wen;
   logic [ADDR_W-1:0] csr_waddr;
   logic [DATA_W-1:0] csr_wdata;
   logic [2:0]        grant;
   logic              busy;

   csr_wport_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_trap_valid (trap_valid),
      .i_trap_last  (trap_last),
      .i_trap_addr  (trap_addr),
      .i_trap_data  (trap_data),
      .o_trap_ready (trap_ready),
      .i_exu_valid  (exu_valid),
      .i_exu_addr   (exu_addr),
      .i_exu_data   (exu_data),
      .o_exu_ready  (exu_ready),
      .i_cnt_valid  (cnt_valid),
      .i_cnt_addr   (cnt_addr),
      .i_cnt_data   (cnt_data),
      .o_cnt_ready  (cnt_ready),
      .o_csr_wen    (csr_wen),
      .o_csr_waddr  (csr_waddr),
      .o_csr_wdata  (csr_wdata),
      .o_grant      (grant),
      .o_busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [2:0]        gnt;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state, kept in spec terms
   bit   m_locked;       // inside a trap burst
   bit   m_cnt_turn;     // counter has the round-robin turn
   int   m_denied;       // consecutive cycles counter was refused

   // Last-cycle acceptance, used to hold payload stable while waiting
   bit   acc_t, acc_e, acc_c;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle of stimulus: drive, check readies/busy, queue the write.
   task automatic step(input bit r,
                       input bit tv, input bit tl, input logic [ADDR_W-1:0] ta, input logic [DATA_W-1:0] td,
                       input bit ev, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                       input bit cv, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd);
      string who;   // "trap", "exu", "cnt" or "" -- which requester the rules pick
      exp_t  e;
      bit    exp_busy;
      @(negedge clk);
      rst_n = r;
      trap_valid = tv; trap_last = tl; trap_addr = ta; trap_data = td;
      exu_valid = ev;  exu_addr = ea;  exu_data = ed;
      cnt_valid = cv;  cnt_addr = ca;  cnt_data = cd;
      #1;
      who = "";
      if (r) begin
         if (m_locked)                           who = tv ? "trap" : "";
         else if (m_denied >= MAX_WAIT && cv)    who = "cnt";
         else if (tv)                            who = "trap";
         else if (ev && cv)                      who = m_cnt_turn ? "cnt" : "exu";
         else if (ev)                            who = "exu";
         else if (cv)                            who = "cnt";
      end
      exp_busy = r && (m_locked || (tv && who != "trap") || (ev && who != "exu") || (cv && who != "cnt"));
      chk("trap_ready", 64'(trap_ready), 64'(who == "trap"));
      chk("exu_ready",  64'(exu_ready),  64'(who == "exu"));
      chk("cnt_ready",  64'(cnt_ready),  64'(who == "cnt"));
      chk("busy",       64'(busy),       64'(exp_busy));

      e.gnt = 3'b000; e.addr = '0; e.data = '0;
      if (who == "trap")     begin e.gnt = 3'b001; e.addr = ta; e.data = td; end
      else if (who == "exu") begin e.gnt = 3'b010; e.addr = ea; e.data = ed; end
      else if (who == "cnt") begin e.gnt = 3'b100; e.addr = ca; e.data = cd; end
      exp_q.push_back(e);

      if (!r) begin
         m_locked = 0; m_cnt_turn = 0; m_denied = 0;
      end else begin
         if (who == "trap") m_locked = !tl;
         if (who == "exu")  m_cnt_turn = 1;
         if (who == "cnt")  m_cnt_turn = 0;
         if (cv && who != "cnt") m_denied = (m_denied + 1 > MAX_WAIT) ? MAX_WAIT : m_denied + 1;
         else                    m_denied = 0;
      end
      acc_t = (who == "trap"); acc_e = (who == "exu"); acc_c = (who == "cnt");
   endtask

   task automatic idle(input bit r);
      step(r, 0, 0, '0, '0, 0, '0, '0, 0, '0, '0);
   endtask

   // Write-port monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("csr_wen",   64'(csr_wen),   64'(e.gnt != 3'b000));
            chk("grant",     64'(grant),     64'(e.gnt));
            chk("csr_waddr", 64'(csr_waddr), 64'(e.addr));
            chk("csr_wdata", csr_wdata,      e.data);
         end else if (csr_wen === 1'b1) begin
            chk("unexpected_wen", 64'(csr_wen), 64'd0);
         end
      end
   end

   initial begin
      bit tv, tl, ev, cv;
      logic [ADDR_W-1:0] ta, ea, ca;
      logic [DATA_W-1:0] td, ed, cd;
      bit r;

      rst_n = 1'b0;
      trap_valid = 0; trap_last = 0; trap_addr = '0; trap_data = '0;
      exu_valid = 0;  exu_addr = '0;  exu_data = '0;
      cnt_valid = 0;  cnt_addr = '0;  cnt_data = '0;
      m_locked = 0; m_cnt_turn = 0; m_denied = 0;

      // Reset, then idle
      idle(0); idle(0);
      for (int i = 0; i < 10; i++) idle(1);

      // Trap burst of three beats with EXU held valid
      step(1, 1, 0, 12'h341, 64'h8000_0010, 1, 12'h305, 64'hE1, 0, '0, '0);
      step(1, 1, 0, 12'h300, 64'h0000_1888, 1, 12'h305, 64'hE1, 0, '0, '0);
      step(1, 1, 1, 12'h342, 64'h0000_000B, 1, 12'h305, 64'hE1, 0, '0, '0);
      step(1, 0, 0, '0, '0,                 1, 12'h305, 64'hE1, 0, '0, '0);
      idle(1);

      // Gapped burst
      step(1, 1, 0, 12'h341, 64'h100, 0, '0, '0, 0, '0, '0);
      step(1, 0, 0, '0, '0, 1, 12'h340, 64'hE2, 1, 12'hB00, 64'hC2);
      step(1, 0, 0, '0, '0, 1, 12'h340, 64'hE2, 1, 12'hB00, 64'hC2);
      step(1, 1, 1, 12'h342, 64'h7, 1, 12'h340, 64'hE2, 1, 12'hB00, 64'hC2);
      step(1, 0, 0, '0, '0, 1, 12'h340, 64'hE2, 1, 12'hB00, 64'hC2);
      idle(1);

      // Round-robin from reset
      idle(0);
      for (int i = 0; i < 4; i++)
         step(1, 0, 0, '0, '0, 1, 12'h340, 64'(i), 1, 12'hB00, 64'(100 + i));
      idle(1);

      // Starvation boost: single-beat traps every cycle
      for (int i = 0; i < 8; i++)
         step(1, 1, 1, 12'h341, 64'(200 + i), 0, '0, '0, 1, 12'hB02, 64'(300 + i));
      idle(1);

      // Reset mid-burst, then a fresh EXU request
      step(1, 1, 0, 12'h341, 64'hAA, 0, '0, '0, 0, '0, '0);
      idle(0);
      step(1, 0, 0, '0, '0, 1, 12'h341, 64'hBB, 0, '0, '0);
      idle(1);

      // Randomized traffic; requesters hold their payload until accepted
      tv = 0; tl = 0; ev = 0; cv = 0; ta = '0; ea = '0; ca = '0; td = '0; ed = '0; cd = '0;
      for (int i = 0; i < 2000; i++) begin
         r = ($urandom_range(0, 199) != 0);
         if (!(tv && !acc_t)) begin
            tv = ($urandom_range(0, 2) == 0);
            tl = ($urandom_range(0, 2) == 0);
            ta = 12'h340 + 12'($urandom_range(0, 3));
            td = {$urandom, $urandom};
         end
         if (!(ev && !acc_e)) begin
            ev = ($urandom_range(0, 1) == 0);
            ea = 12'h340 + 12'($urandom_range(0, 3));
            ed = {$urandom, $urandom};
         end
         if (!(cv && !acc_c)) begin
            cv = ($urandom_range(0, 1) == 0);
            ca = 12'hB00 + 12'($urandom_range(0, 2));
            cd = {$urandom, $urandom};
         end
         step(r, tv, tl, ta, td, ev, ea, ed, cv, ca, cd);
      end
      idle(1); idle(1);

      @(negedge clk);
      if (exp_q.size() != 0) chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/csr_wport_arbiter.md
Name: csr_wport_arbiter

Overview:
- Shares the single CSR-file write port between three requesters:
  - the trap/interrupt sequencer, which writes MEPC, MSTATUS and MCAUSE as a multi-beat burst;
  - EXU CSR instructions (csrrw/csrrs/csrrc writeback);
  - the counter updater (mcycle/minstret).
- Sits between these sources and the CSR register file.
- Provides the trap sequencer with atomic bursts, fixed-priority access for traps, round-robin between EXU and counter, and anti-starvation for the counter.
- The write port is registered, with one-cycle latency.

Parameters:
- ADDR_W, 12, CSR address width.
- DATA_W, 64, CSR data width.
- MAX_WAIT, 8, consecutive denied cycles after which the counter requester is boosted; legal range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- i_trap_valid  in  1  trap-sequencer write request
- i_trap_last  in  1  final beat of a trap burst
- i_trap_addr  in  ADDR_W  trap write address
- i_trap_data  in  DATA_W  trap write data
- o_trap_ready  out  1  trap beat accepted this cycle
- i_exu_valid  in  1  EXU CSR write request
- i_exu_addr  in  ADDR_W  EXU write address
- i_exu_data  in  DATA_W  EXU write data
- o_exu_ready  out  1  EXU beat accepted
- i_cnt_valid  in  1  counter write request
- i_cnt_addr  in  ADDR_W  counter write address
- i_cnt_data  in  DATA_W  counter write data
- o_cnt_ready  out  1  counter beat accepted
- o_csr_wen  out  1  registered write enable to CSR file
- o_csr_waddr  out  ADDR_W  registered write address
- o_csr_wdata  out  DATA_W  registered write data
- o_grant  out  3  registered one-hot of the source written this cycle, {cnt, exu, trap}
- o_busy  out  1  burst lock active, or any valid request not granted this cycle (used as a stall to IDU)

Behaviour:
- Handshake:
  - A transfer occurs when valid & ready on the same cycle.
  - ready is combinational from the valids and the internal state; at most one ready is high per cycle.
  - ready never depends on itself; a requester may hold valid indefinitely.
- Grant order, evaluated each cycle:
  1. lock=1: only trap is eligible. If i_trap_valid=0, no grant and lock holds.
  2. boost (wait_cnt==MAX_WAIT) & i_cnt_valid: cnt is granted, even over trap.
  3. i_trap_valid: trap is granted.
  4. exu vs cnt round-robin: rr_ptr=0 prefers exu, rr_ptr=1 prefers cnt. If only one is valid, that one is granted.
- rr_ptr update:
  - After an exu transfer, rr_ptr<=1.
  - After a cnt transfer (including a boosted one), rr_ptr<=0.
  - Unchanged otherwise.
- lock:
  - Set on a trap transfer with i_trap_last=0.
  - Cleared on a trap transfer with i_trap_last=1.
  - A single-beat trap (last=1 on the first beat) never sets lock.
  - Boost cannot preempt a locked burst; it waits until lock clears.
- wait_cnt (8-bit, saturating at MAX_WAIT):
  - Increments each cycle that i_cnt_valid=1 and o_cnt_ready=0.
  - Clears to 0 on a cnt transfer or when i_cnt_valid=0.
- Write port:
  - The cycle after a transfer: o_csr_wen=1, addr/data are the granted source's values, and o_grant is one-hot for that source.
  - Cycles with no transfer: wen=0, waddr=0, wdata=0, o_grant=0.
  - Back-to-back transfers give back-to-back writes (full throughput).
- Same-cycle requests to the same address from different sources are serialized in grant order. No merging is done; the later write wins in the CSR file.
- o_busy is combinational: lock | (i_trap_valid & ~o_trap_ready) | (i_exu_valid & ~o_exu_ready) | (i_cnt_valid & ~o_cnt_ready).
- Reset (rst_n=0 at posedge):
  - State: lock=0, rr_ptr=0, wait_cnt=0.
  - Outputs: o_csr_wen=0, o_csr_waddr=0, o_csr_wdata=0, o_grant=0.
  - While rst_n=0, all readies are forced to 0 and o_busy=0.
  - Reset mid-burst discards the lock; the trap sequencer restarts its burst from beat 0.

Test Plan:
- Trap burst with EXU contention: trap issues 3 beats (MEPC 0x341 data 0x8000_0010, MSTATUS 0x300, MCAUSE 0x342 data 0xB, last on beat 3) while exu_valid is held throughout.
  - trap_ready must be 1,1,1.
  - wen must be high for 3 consecutive cycles starting 1 cycle later, with addrs 0x341, 0x300, 0x342.
  - exu is granted on the 4th cycle; o_busy=1 during the burst.
- Gapped burst: trap beat 1 (last=0), trap_valid=0 for 2 cycles while exu and cnt are valid, then beat 2 (last=1).
  - No grant in the gap cycles.
  - exu is granted only after beat 2.
- Round-robin: exu and cnt both valid continuously with no trap.
  - Grants alternate exu, cnt, exu, cnt starting from exu after reset.
  - o_grant sequence is 010, 100, 010, 100.
- Starvation boost: MAX_WAIT=4; trap issues single-beat requests every cycle while cnt_valid=1.
  - cnt is denied for 4 cycles, then granted on the 5th over trap.
  - wait_cnt clears; trap resumes the following cycle.
- Reset mid-burst: assert rst_n=0 after trap beat 1 (last=0), then release.
  - Outputs are 0 the cycle after reset.
  - A fresh exu request is granted immediately, proving the lock was cleared.
- Idle: no valids for 10 cycles.
  - wen=0, addr=0, data=0, o_grant=0, o_busy=0, all readies 0.
